// File: rtl/dlfpu_op_scheduler_if.sv
// Bundle of request, FPU and response signals for dlfpu_op_scheduler.
// The slave modport is the scheduler's view; master is the environment
// (requesters, FPU core and response consumer) that surrounds it.
interface dlfpu_op_scheduler_if #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [4*NUM_REQ-1:0]  req_op;
  logic [32*NUM_REQ-1:0] req_a;
  logic [16*NUM_REQ-1:0] req_b;

  logic [3:0]            fpu_ena;
  logic [31:0]           fpu_a;
  logic [15:0]           fpu_b;
  logic [15:0]           fpu_result;
  logic [4:0]            fpu_exc;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [15:0]           rsp_result;
  logic [4:0]            rsp_exc;

  logic                  busy;

  modport master (
    output req_valid, req_op, req_a, req_b, fpu_result, fpu_exc, rsp_ready,
    input  req_ready, fpu_ena, fpu_a, fpu_b, rsp_valid, rsp_id, rsp_result,
           rsp_exc, busy
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, fpu_result, fpu_exc, rsp_ready,
    output req_ready, fpu_ena, fpu_a, fpu_b, rsp_valid, rsp_id, rsp_result,
           rsp_exc, busy
  );
endinterface

// File: rtl/dlfpu_op_scheduler.sv
// Round-robin scheduler sharing one DL-FPU unit between NUM_REQ requesters.
// A granted request drives the FPU for FPU_LAT+1 cycles, the result and
// flags are captured on the last of them and held until the response is
// taken. Opcode 4'b0000 is answered directly with an invalid-op flag.
// Optional feature: define DLFPU_SCHED_PRIO_EN to give requester 0 strict
// priority, with round-robin among the remaining requesters.
module dlfpu_op_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int FPU_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dlfpu_op_scheduler_if.slave  bus
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [3:0]      fpu_ena_q, fpu_ena_d;
  logic [31:0]     fpu_a_q, fpu_a_d;
  logic [15:0]     fpu_b_q, fpu_b_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [15:0]     rsp_result_q, rsp_result_d;
  logic [4:0]      rsp_exc_q, rsp_exc_d;
  logic            busy_q, busy_d;

  logic            grant_vld;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] cand;
  logic            cand_ok;
  logic [3:0]      grant_op;
  logic [31:0]     grant_a;
  logic [15:0]     grant_b;
  logic [NUM_REQ-1:0] req_ready;

  // Arbiter: first valid requester found after the pointer, wrapping around.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = ptr_q;
    cand_ok   = 1'b0;
`ifdef DLFPU_SCHED_PRIO_EN
    if (bus.req_valid[0]) begin
      grant_vld = 1'b1;
      grant_idx = '0;
    end
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
      cand    = (cand == LAST_ID) ? '0 : cand + 1'b1;
      cand_ok = bus.req_valid[cand];
`ifdef DLFPU_SCHED_PRIO_EN
      cand_ok = cand_ok && (cand != '0);
`endif
      if (!grant_vld && cand_ok) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Operand mux for the winning requester and the one-hot accept.
  always_comb begin
    grant_op  = bus.req_op[{grant_idx, 2'b00} +: 4];
    grant_a   = bus.req_a[{grant_idx, 5'b00000} +: 32];
    grant_b   = bus.req_b[{grant_idx, 4'b0000} +: 16];
    req_ready = '0;
    if ((state_q == IDLE) && grant_vld) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Next-state and registered-output computation for the sequencer.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    fpu_ena_d    = fpu_ena_q;
    fpu_a_d      = fpu_a_q;
    fpu_b_d      = fpu_b_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_exc_d    = rsp_exc_q;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          rsp_id_d = grant_idx;
`ifdef DLFPU_SCHED_PRIO_EN
          if (grant_idx != '0) begin
            ptr_d = grant_idx;
          end
`else
          ptr_d = grant_idx;
`endif
          if (grant_op == 4'b0000) begin
            state_d      = RESP;
            rsp_valid_d  = 1'b1;
            rsp_result_d = 16'h0000;
            rsp_exc_d    = 5'b00001;
          end else begin
            state_d   = EXEC;
            cnt_d     = 3'(FPU_LAT);
            fpu_ena_d = grant_op;
            fpu_a_d   = grant_a;
            fpu_b_d   = grant_b;
          end
        end
      end
      EXEC: begin
        if (cnt_q == 3'd0) begin
          state_d      = RESP;
          rsp_valid_d  = 1'b1;
          rsp_result_d = bus.fpu_result;
          rsp_exc_d    = bus.fpu_exc;
          fpu_ena_d    = 4'b0000;
          fpu_a_d      = '0;
          fpu_b_d      = '0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
        fpu_ena_d   = 4'b0000;
        fpu_a_d     = '0;
        fpu_b_d     = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State register; an asynchronous reset drops any in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= LAST_ID;
      cnt_q        <= 3'd0;
      fpu_ena_q    <= 4'b0000;
      fpu_a_q      <= '0;
      fpu_b_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_exc_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      fpu_ena_q    <= fpu_ena_d;
      fpu_a_q      <= fpu_a_d;
      fpu_b_q      <= fpu_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_exc_q    <= rsp_exc_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.fpu_ena    = fpu_ena_q;
  assign bus.fpu_a      = fpu_a_q;
  assign bus.fpu_b      = fpu_b_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_exc    = rsp_exc_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_dlfpu_op_scheduler.sv
// Directed bench for dlfpu_op_scheduler: one instance with FPU_LAT=1 for
// arbitration, response and reset behaviour, a second with FPU_LAT=3 for
// the capture timing. Each instance gets a small FPU model whose output is
// garbage until the unit latency has elapsed.
module tb_dlfpu_op_scheduler;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   waitCnt;
  int   rspSeen;
  int   lat1Cnt;
  int   lat3Cnt;
  logic [3:0] expGrant;

  dlfpu_op_scheduler_if #(.NUM_REQ(4)) if1 ();
  dlfpu_op_scheduler_if #(.NUM_REQ(4)) if3 ();

  dlfpu_op_scheduler #(.NUM_REQ(4), .FPU_LAT(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  dlfpu_op_scheduler #(.NUM_REQ(4), .FPU_LAT(3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if3)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count how long each FPU model has seen a non-idle opcode.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat1Cnt <= 0;
      lat3Cnt <= 0;
    end else begin
      if (if1.fpu_ena == 4'b0000) lat1Cnt <= 0;
      else if (lat1Cnt < 7) lat1Cnt <= lat1Cnt + 1;
      if (if3.fpu_ena == 4'b0000) lat3Cnt <= 0;
      else if (lat3Cnt < 7) lat3Cnt <= lat3Cnt + 1;
    end
  end

  // FPU models: zero when idle, DEAD/all-flags before the latency expires.
  assign if1.fpu_result = (if1.fpu_ena == 4'b0000) ? 16'h0000 :
                          (lat1Cnt >= 1) ? (if1.fpu_a[15:0] ^ if1.fpu_b ^ 16'h4355) : 16'hDEAD;
  assign if1.fpu_exc    = (if1.fpu_ena == 4'b0000) ? 5'b00000 :
                          (lat1Cnt >= 1) ? ({1'b0, if1.fpu_ena} ^ if1.fpu_a[4:0]) : 5'b11111;
  assign if3.fpu_result = (if3.fpu_ena == 4'b0000) ? 16'h0000 :
                          (lat3Cnt >= 3) ? (if3.fpu_a[15:0] ^ if3.fpu_b ^ 16'h4355) : 16'hDEAD;
  assign if3.fpu_exc    = (if3.fpu_ena == 4'b0000) ? 5'b00000 :
                          (lat3Cnt >= 3) ? ({1'b0, if3.fpu_ena} ^ if3.fpu_a[4:0]) : 5'b11111;

  // Raise one requester with its opcode and operands on the chosen instance.
  task automatic applyStimulus(input bit useLat3, input int idx, input logic [3:0] op,
                               input logic [31:0] a, input logic [15:0] b);
    if (useLat3) begin
      if3.req_valid[idx]         = 1'b1;
      if3.req_op[idx*4 +: 4]     = op;
      if3.req_a[idx*32 +: 32]    = a;
      if3.req_b[idx*16 +: 16]    = b;
    end else begin
      if1.req_valid[idx]         = 1'b1;
      if1.req_op[idx*4 +: 4]     = op;
      if1.req_a[idx*32 +: 32]    = a;
      if1.req_b[idx*16 +: 16]    = b;
    end
  endtask

  // One comparison: count it, and on mismatch count and report the failure.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Step to the next falling edge and let inputs settle.
  task automatic nextCycle();
    @(negedge clk);
    #1;
  endtask

  // Directed sequence of all test steps.
  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    if1.req_valid = '0; if1.req_op = '0; if1.req_a = '0; if1.req_b = '0; if1.rsp_ready = 1'b0;
    if3.req_valid = '0; if3.req_op = '0; if3.req_a = '0; if3.req_b = '0; if3.rsp_ready = 1'b0;
    #2;
    $display("[TB] reset state");
    checkOutput("rst_req_ready", if1.req_ready, 0);
    checkOutput("rst_fpu_ena", if1.fpu_ena, 0);
    checkOutput("rst_fpu_a", if1.fpu_a, 0);
    checkOutput("rst_fpu_b", if1.fpu_b, 0);
    checkOutput("rst_rsp_valid", if1.rsp_valid, 0);
    checkOutput("rst_rsp_id", if1.rsp_id, 0);
    checkOutput("rst_rsp_result", if1.rsp_result, 0);
    checkOutput("rst_rsp_exc", if1.rsp_exc, 0);
    checkOutput("rst_busy", if1.busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    nextCycle();

    $display("[TB] round-robin fairness");
    if1.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, i, 4'(i + 1), 32'(i + 10), 16'h0000);
    #1;
    for (int n = 0; n < 5; n++) begin
      waitCnt = 0;
      while (if1.req_ready == 4'b0000 && waitCnt < 20) begin
        nextCycle();
        waitCnt++;
      end
`ifdef DLFPU_SCHED_PRIO_EN
      expGrant = 4'b0001;
`else
      expGrant = 4'b0001 << (n % 4);
`endif
      checkOutput("rr_grant", if1.req_ready, expGrant);
      nextCycle();
    end
    if1.req_valid = '0;
    nextCycle();
    nextCycle();
    checkOutput("rr_last_valid", if1.rsp_valid, 1);
    checkOutput("rr_last_id", if1.rsp_id, 0);
    checkOutput("rr_last_result", if1.rsp_result, 32'h435F);
    nextCycle();
    checkOutput("rr_idle_busy", if1.busy, 0);

    $display("[TB] single request with backpressure");
    if1.rsp_ready = 1'b0;
    applyStimulus(1'b0, 2, 4'b0111, 32'd5, 16'h0000);
    #1;
    checkOutput("single_grant", if1.req_ready, 4'b0100);
    nextCycle();
    if1.req_valid = '0;
    checkOutput("single_ena_c1", if1.fpu_ena, 4'b0111);
    checkOutput("single_a_c1", if1.fpu_a, 32'd5);
    checkOutput("single_busy", if1.busy, 1);
    checkOutput("single_no_ready", if1.req_ready, 0);
    nextCycle();
    checkOutput("single_ena_c2", if1.fpu_ena, 4'b0111);
    checkOutput("single_no_rsp_yet", if1.rsp_valid, 0);
    nextCycle();
    checkOutput("single_rsp_valid", if1.rsp_valid, 1);
    checkOutput("single_rsp_id", if1.rsp_id, 2);
    checkOutput("single_rsp_result", if1.rsp_result, 32'h4350);
    checkOutput("single_rsp_exc", if1.rsp_exc, 5'b00010);
    checkOutput("single_ena_off", if1.fpu_ena, 0);
    applyStimulus(1'b0, 1, 4'b0000, 32'h0000_1234, 16'h0055);
    for (int k = 0; k < 5; k++) begin
      nextCycle();
      checkOutput("bp_rsp_valid", if1.rsp_valid, 1);
      checkOutput("bp_rsp_id", if1.rsp_id, 2);
      checkOutput("bp_rsp_result", if1.rsp_result, 32'h4350);
      checkOutput("bp_req_ready", if1.req_ready, 0);
      checkOutput("bp_fpu_ena", if1.fpu_ena, 0);
    end

    $display("[TB] release and illegal opcode");
    if1.rsp_ready = 1'b1;
    nextCycle();
    checkOutput("rel_rsp_valid", if1.rsp_valid, 0);
    checkOutput("rel_busy", if1.busy, 0);
    checkOutput("illegal_grant", if1.req_ready, 4'b0010);
    nextCycle();
    if1.req_valid = '0;
    checkOutput("illegal_rsp_valid", if1.rsp_valid, 1);
    checkOutput("illegal_rsp_id", if1.rsp_id, 1);
    checkOutput("illegal_rsp_result", if1.rsp_result, 0);
    checkOutput("illegal_rsp_exc", if1.rsp_exc, 5'b00001);
    checkOutput("illegal_no_ena", if1.fpu_ena, 0);
    nextCycle();
    checkOutput("illegal_done", if1.rsp_valid, 0);
    checkOutput("illegal_idle", if1.busy, 0);

    $display("[TB] reset during execution");
    applyStimulus(1'b0, 3, 4'b0101, 32'h0000_0077, 16'h0001);
    #1;
    checkOutput("rexec_grant", if1.req_ready, 4'b1000);
    nextCycle();
    if1.req_valid = '0;
    checkOutput("rexec_in_exec", if1.fpu_ena, 4'b0101);
    rst_n = 1'b0;
    #1;
    checkOutput("rexec_busy", if1.busy, 0);
    checkOutput("rexec_fpu_ena", if1.fpu_ena, 0);
    checkOutput("rexec_fpu_a", if1.fpu_a, 0);
    checkOutput("rexec_rsp_valid", if1.rsp_valid, 0);
    checkOutput("rexec_rsp_id", if1.rsp_id, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rspSeen = 0;
    for (int k = 0; k < 6; k++) begin
      nextCycle();
      if (if1.rsp_valid === 1'b1) rspSeen++;
    end
    checkOutput("rexec_no_rsp", rspSeen, 0);
    applyStimulus(1'b0, 0, 4'b0011, 32'h0000_0001, 16'h0000);
    applyStimulus(1'b0, 3, 4'b0011, 32'h0000_0002, 16'h0000);
    #1;
    checkOutput("rexec_first_grant", if1.req_ready, 4'b0001);
    nextCycle();
    if1.req_valid = '0;
    for (int k = 0; k < 4; k++) nextCycle();
    checkOutput("rexec_done", if1.busy, 0);

    $display("[TB] latency three capture");
    applyStimulus(1'b1, 0, 4'b1001, 32'h0000_1234, 16'h0F0F);
    #1;
    checkOutput("lat3_grant", if3.req_ready, 4'b0001);
    for (int k = 0; k < 4; k++) begin
      nextCycle();
      if3.req_valid = '0;
      checkOutput("lat3_ena", if3.fpu_ena, 4'b1001);
      checkOutput("lat3_no_rsp", if3.rsp_valid, 0);
    end
    nextCycle();
    checkOutput("lat3_ena_off", if3.fpu_ena, 0);
    checkOutput("lat3_rsp_valid", if3.rsp_valid, 1);
    checkOutput("lat3_rsp_result", if3.rsp_result, 32'h5E6E);
    checkOutput("lat3_rsp_exc", if3.rsp_exc, 5'b11101);
    if3.rsp_ready = 1'b1;
    nextCycle();
    checkOutput("lat3_idle", if3.busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
